envelope_port_arbiter: RTL and testbench

//  Packet-boundary arbiter sharing one sample/tuser output (one chdr_framer and one str_src port)

---
 rtl/envelope_port_arbiter.sv | 101 ++++++++++
 tb/tb_envelope_port_arbiter.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/envelope_port_arbiter.sv
// envelope_port_arbiter: packet-boundary arbiter merging two sample streams onto one registered output.
// Define ENVELOPE_ARB_STATS_EN to add per-port packet counters on rb_data.
module envelope_port_arbiter #(
    parameter int         WIDTH       = 32,
    parameter logic [7:0] SR_ARB_CTRL = 8'd130
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic [WIDTH-1:0] i0_tdata,
    input  logic [127:0]     i0_tuser,
    input  logic             i0_tlast,
    input  logic             i0_tvalid,
    output logic             i0_tready,
    input  logic [WIDTH-1:0] i1_tdata,
    input  logic [127:0]     i1_tuser,
    input  logic             i1_tlast,
    input  logic             i1_tvalid,
    output logic             i1_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic [127:0]     o_tuser,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic             o_port,
    output logic [63:0]      rb_data
);
    typedef enum logic [1:0] {IDLE, PKT0, PKT1} state_t;
    state_t     state, state_nxt;
    logic [1:0] en_mask, req;
    logic       fixed_prio, rr_ptr, out_rdy, acc0, acc1, done0, done1, unused_bits;
    assign req         = {i1_tvalid & en_mask[1], i0_tvalid & en_mask[0]};
    assign out_rdy     = ~o_tvalid | o_tready;
    assign i0_tready   = (state == PKT0) & out_rdy;
    assign i1_tready   = (state == PKT1) & out_rdy;
    assign acc0        = i0_tvalid & i0_tready;
    assign acc1        = i1_tvalid & i1_tready;
    assign done0       = acc0 & i0_tlast;
    assign done1       = acc1 & i1_tlast;
    assign unused_bits = ^set_data[31:3];
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (req[0] && (!req[1] || fixed_prio || !rr_ptr)) ? PKT0 : req[1] ? PKT1 : IDLE;
            PKT0:    state_nxt = done0 ? IDLE : PKT0;
            PKT1:    state_nxt = done1 ? IDLE : PKT1;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            en_mask    <= 2'b11;
            fixed_prio <= 1'b0;
            o_tdata    <= '0;
            o_tuser    <= '0;
            o_tlast    <= 1'b0;
            o_tvalid   <= 1'b0;
            o_port     <= 1'b0;
        end else begin
            if (set_stb && set_addr == SR_ARB_CTRL) {fixed_prio, en_mask} <= set_data[2:0];
            if (clear) begin
                state    <= IDLE;
                rr_ptr   <= 1'b0;
                o_tvalid <= 1'b0;
            end else begin
                state <= state_nxt;
                // after port n finishes, the other port has priority
                if (done0 || done1) rr_ptr <= done0;
                if (acc0 || acc1) begin
                    o_tdata  <= acc1 ? i1_tdata : i0_tdata;
                    o_tuser  <= acc1 ? i1_tuser : i0_tuser;
                    o_tlast  <= acc1 ? i1_tlast : i0_tlast;
                    o_port   <= acc1;
                    o_tvalid <= 1'b1;
                end else if (o_tready) begin
                    o_tvalid <= 1'b0;
                end
            end
        end
    end
`ifdef ENVELOPE_ARB_STATS_EN
    logic [31:0] pkt_cnt0, pkt_cnt1;
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else begin
            if (done0) pkt_cnt0 <= pkt_cnt0 + 32'd1;
            if (done1) pkt_cnt1 <= pkt_cnt1 + 32'd1;
        end
    end
    assign rb_data = {pkt_cnt1, pkt_cnt0};
`else
    assign rb_data = 64'd0;
`endif
endmodule

// File: tb/tb_envelope_port_arbiter.sv
// tb_envelope_port_arbiter: randomized packet traffic against a per-port scoreboard and arbitration-order model.
module tb_envelope_port_arbiter;
    localparam int W = 32;
    logic           clk = 1'b0, reset = 1'b1, clear = 1'b0, set_stb = 1'b0;
    logic [7:0]     set_addr = '0;
    logic [31:0]    set_data = '0;
    logic [W-1:0]   i0_tdata = '0, i1_tdata = '0, o_tdata;
    logic [127:0]   i0_tuser = '0, i1_tuser = '0, o_tuser;
    logic           i0_tlast = 1'b0, i0_tvalid = 1'b0, i0_tready;
    logic           i1_tlast = 1'b0, i1_tvalid = 1'b0, i1_tready;
    logic           o_tlast, o_tvalid, o_port, o_tready = 1'b1;
    logic [63:0]    rb_data;

    envelope_port_arbiter #(.WIDTH(W), .SR_ARB_CTRL(8'd130)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i0_tdata(i0_tdata), .i0_tuser(i0_tuser), .i0_tlast(i0_tlast), .i0_tvalid(i0_tvalid), .i0_tready(i0_tready),
        .i1_tdata(i1_tdata), .i1_tuser(i1_tuser), .i1_tlast(i1_tlast), .i1_tvalid(i1_tvalid), .i1_tready(i1_tready),
        .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .o_port(o_port), .rb_data(rb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic [127:0] u;
        logic         l;
    } beat_t;

    beat_t src_q[2][$];
    beat_t exp_q[2][$];
    int    obs_port[$], obs_first[$], obs_last[$];
    int    checks = 0, errors = 0, cyc = 0, bubble_pct = 0, sink_mode = 0, first_cyc = 0;
    int    done_cnt[2] = '{0, 0};
    bit    mon_first = 1'b1, stall_prev = 1'b0;

    task automatic add_pkt(input int p, input int len, input bit inc, input int base);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.d = inc ? W'(base + k) : $urandom;
            b.u = {$urandom, $urandom, $urandom, $urandom};
            b.l = (k == len - 1);
            src_q[p].push_back(b);
            exp_q[p].push_back(b);
        end
    endtask

    task automatic present(input int p);
        logic  v;
        beat_t b;
        b.d = '0;
        b.u = '0;
        b.l = 1'b0;
        v = src_q[p].size() > 0 && int'($urandom_range(99)) >= bubble_pct;
        if (v) b = src_q[p][0];
        if (p == 0) begin
            i0_tvalid = v; i0_tdata = b.d; i0_tuser = b.u; i0_tlast = b.l;
        end else begin
            i1_tvalid = v; i1_tdata = b.d; i1_tuser = b.u; i1_tlast = b.l;
        end
    endtask

    // a beat shown before an edge with tvalid & tready high is consumed by that edge
    task automatic drive_port(input int p);
        logic f;
        forever begin
            @(negedge clk);
            f = (p == 0) ? (i0_tvalid && i0_tready) : (i1_tvalid && i1_tready);
            @(posedge clk);
            #1;
            if (f && src_q[p].size() > 0) void'(src_q[p].pop_front());
            present(p);
        end
    endtask

    initial drive_port(0);
    initial drive_port(1);

    initial forever begin
        @(posedge clk);
        #1;
        o_tready = (sink_mode == 0) ? 1'b1 : (sink_mode == 1) ? ~o_tready : 1'($urandom_range(1));
    end

    initial begin : mon
        beat_t e, sv;
        logic  sv_p;
        sv_p = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (stall_prev) begin
                checks++;
                if (o_tvalid !== 1'b1 || o_tdata !== sv.d || o_tuser !== sv.u || o_tlast !== sv.l || o_port !== sv_p) begin
                    errors++;
                    $display("FAIL hold_stable cyc %0d: got v=%b d=%h l=%b p=%b, need v=1 d=%h l=%b p=%b",
                             cyc, o_tvalid, o_tdata, o_tlast, o_port, sv.d, sv.l, sv_p);
                end
            end
            if (o_tvalid === 1'b1 && o_tready) begin
                checks++;
                if (exp_q[o_port].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat cyc %0d: port %0d data %h, need no beat", cyc, o_port, o_tdata);
                end else begin
                    e = exp_q[o_port].pop_front();
                    if (o_tdata !== e.d || o_tuser !== e.u || o_tlast !== e.l) begin
                        errors++;
                        $display("FAIL beat_data cyc %0d port %0d: got d=%h l=%b u=%h, need d=%h l=%b u=%h",
                                 cyc, o_port, o_tdata, o_tlast, o_tuser, e.d, e.l, e.u);
                    end
                end
                if (mon_first) first_cyc = cyc;
                mon_first = o_tlast;
                if (o_tlast) begin
                    obs_port.push_back(int'(o_port));
                    obs_first.push_back(first_cyc);
                    obs_last.push_back(cyc);
                    done_cnt[o_port]++;
                end
            end
            stall_prev = o_tvalid === 1'b1 && !o_tready;
            sv.d = o_tdata; sv.u = o_tuser; sv.l = o_tlast; sv_p = o_port;
        end
    end

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic write_ctrl(input logic [7:0] a, input logic [31:0] d);
        sync();
        set_stb = 1'b1; set_addr = a; set_data = d;
        sync();
        set_stb = 1'b0;
    endtask

    task automatic wait_pkts(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            #1;
            ok = obs_port.size() >= n;
        end
    endtask

    task automatic clear_obs();
        obs_port.delete(); obs_first.delete(); obs_last.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({o_tvalid, o_tlast, o_port} !== 3'b000) begin
            errors++; $display("FAIL reset_ctl: got v/l/p=%b%b%b, need 000", o_tvalid, o_tlast, o_port);
        end
        checks++;
        if ({i0_tready, i1_tready} !== 2'b00) begin
            errors++; $display("FAIL reset_tready: got %b%b, need 00", i0_tready, i1_tready);
        end
        checks++;
        if (o_tdata !== '0 || o_tuser !== '0) begin
            errors++; $display("FAIL reset_data: got d=%h u=%h, need 0", o_tdata, o_tuser);
        end
        checks++;
        if (rb_data !== 64'd0) begin
            errors++; $display("FAIL reset_rb: got %h, need 0", rb_data);
        end
        write_ctrl(8'd131, 32'd0);
    endtask

    task automatic test_round_robin();
        bit ok;
        clear_obs();
        sync();
        for (int k = 0; k < 4; k++) begin
            add_pkt(0, 3, 1'b0, 0);
            add_pkt(1, 3, 1'b0, 0);
        end
        wait_pkts(8, 300, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL rr_timeout: got %0d pkts, need 8", obs_port.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (obs_port[k] !== k % 2) begin
                    errors++; $display("FAIL rr_order pkt %0d: got port %0d, need %0d", k, obs_port[k], k % 2);
                end
            end
            for (int k = 1; k < 8; k++) begin
                checks++;
                if (obs_first[k] - obs_last[k-1] !== 2) begin
                    errors++; $display("FAIL rr_gap pkt %0d: got %0d cycles, need 2", k, obs_first[k] - obs_last[k-1]);
                end
            end
        end
    endtask

    task automatic test_fixed_prio();
        bit ok;
        int bad;
        write_ctrl(8'd130, 32'h7);
        clear_obs();
        sync();
        for (int k = 0; k < 3; k++) begin
            add_pkt(0, 2, 1'b0, 0);
            add_pkt(1, 2, 1'b0, 0);
        end
        ok = 1'b0;
        bad = 0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            #1;
            if (obs_port.size() < 3 && i1_tready) bad++;
            ok = obs_port.size() >= 6;
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL fixed_timeout: got %0d pkts, need 6", obs_port.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (obs_port[k] !== k / 3) begin
                    errors++; $display("FAIL fixed_order pkt %0d: got port %0d, need %0d", k, obs_port[k], k / 3);
                end
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL fixed_i1_tready: got %0d busy cycles, need 0", bad);
        end
        write_ctrl(8'd130, 32'h3);
    endtask

    task automatic test_disable_mid();
        bit ok, found;
        int bad;
        clear_obs();
        sync();
        add_pkt(0, 4, 1'b1, 200);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            #1;
            found = i0_tvalid && i0_tready && i0_tdata == 201;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL dis_start: got no port-0 beat 1, need one");
        end
        set_stb = 1'b1; set_addr = 8'd130; set_data = 32'h2;
        add_pkt(0, 2, 1'b0, 0); add_pkt(0, 2, 1'b0, 0);
        add_pkt(1, 2, 1'b0, 0); add_pkt(1, 2, 1'b0, 0);
        sync();
        set_stb = 1'b0;
        wait_pkts(3, 200, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL dis_timeout: got %0d pkts, need 3", obs_port.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_port[k] !== (k == 0 ? 0 : 1)) begin
                    errors++; $display("FAIL dis_order pkt %0d: got port %0d, need %0d", k, obs_port[k], k == 0 ? 0 : 1);
                end
            end
        end
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (i0_tready) bad++;
        end
        checks++;
        if (bad !== 0 || src_q[0].size() !== 4 || obs_port.size() !== 3) begin
            errors++;
            $display("FAIL dis_blocked: got ready=%0d left=%0d pkts=%0d, need 0 4 3", bad, src_q[0].size(), obs_port.size());
        end
        sync();
        src_q[0].delete(); exp_q[0].delete();
        i0_tvalid = 1'b0;
        write_ctrl(8'd130, 32'h3);
    endtask

    task automatic test_stall();
        int           n;
        logic [W-1:0] got[8];
        logic         gl[8];
        sink_mode = 1;
        sync();
        add_pkt(1, 8, 1'b1, 0);
        n = 0;
        for (int k = 0; k < 200 && n < 8; k++) begin
            @(negedge clk);
            #1;
            if (o_tvalid && o_tready) begin
                got[n] = o_tdata; gl[n] = o_tlast; n++;
            end
        end
        checks++;
        if (n !== 8) begin
            errors++; $display("FAIL stall_count: got %0d beats, need 8", n);
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (got[k] !== W'(k) || gl[k] !== (k == 7)) begin
                    errors++; $display("FAIL stall_beat %0d: got d=%0d l=%b, need d=%0d l=%b", k, got[k], gl[k], k, k == 7);
                end
            end
        end
        sink_mode = 0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_clear();
        bit ok, found;
        int bad;
        clear_obs();
        sync();
        add_pkt(0, 2, 1'b0, 0);
        wait_pkts(1, 100, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL clr_prep: got no port-0 pkt, need one");
        end
        sync();
        add_pkt(1, 5, 1'b1, 100);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            #1;
            found = i1_tvalid && i1_tready && i1_tdata == 102;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL clr_start: got no port-1 beat 2, need one");
        end
        clear = 1'b1;
        sync();
        clear = 1'b0;
        src_q[1].delete(); exp_q[1].delete();
        i1_tvalid = 1'b0;
        mon_first = 1'b1;
        done_cnt = '{0, 0};
        @(negedge clk);
        #1;
        checks++;
        if (o_tvalid !== 1'b0 || {i0_tready, i1_tready} !== 2'b00) begin
            errors++; $display("FAIL clr_idle: got v=%b rdy=%b%b, need 0 00", o_tvalid, i0_tready, i1_tready);
        end
        clear_obs();
        add_pkt(0, 2, 1'b0, 0);
        add_pkt(1, 2, 1'b0, 0);
        wait_pkts(2, 100, ok);
        checks++;
        if (!ok || obs_port[0] !== 0 || obs_port[1] !== 1) begin
            errors++; $display("FAIL clr_grant: got %0d pkts first port %0d, need 2 pkts port 0 first",
                               obs_port.size(), ok ? obs_port[0] : -1);
        end
        sync();
        clear = 1'b1; set_stb = 1'b1; set_addr = 8'd130; set_data = 32'h5;
        sync();
        clear = 1'b0; set_stb = 1'b0;
        done_cnt = '{0, 0};
        clear_obs();
        add_pkt(1, 2, 1'b0, 0);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (i1_tready) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL clr_set_both: got %0d port-1 ready cycles, need 0", bad);
        end
        write_ctrl(8'd130, 32'h3);
        wait_pkts(1, 100, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL clr_reenable: got no port-1 pkt, need one");
        end
    endtask

    task automatic test_random();
        bit ok;
        bubble_pct = 30;
        sink_mode = 2;
        clear_obs();
        sync();
        for (int k = 0; k < 12; k++) begin
            add_pkt(0, int'($urandom_range(6, 1)), 1'b0, 0);
            add_pkt(1, int'($urandom_range(6, 1)), 1'b0, 0);
        end
        ok = 1'b0;
        for (int k = 0; k < 4000 && !ok; k++) begin
            @(negedge clk);
            #1;
            ok = exp_q[0].size() == 0 && exp_q[1].size() == 0;
        end
        checks++;
        if (!ok || obs_port.size() !== 24) begin
            errors++; $display("FAIL rand_drain: got %0d pkts left %0d/%0d, need 24 0/0",
                               obs_port.size(), exp_q[0].size(), exp_q[1].size());
        end
        bubble_pct = 0;
        sink_mode = 0;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_stats();
`ifdef ENVELOPE_ARB_STATS_EN
        bit          ok;
        logic [31:0] hi;
        @(negedge clk);
        checks++;
        if (rb_data !== {32'(done_cnt[1]), 32'(done_cnt[0])}) begin
            errors++; $display("FAIL stats_count: got %h, need %h", rb_data, {32'(done_cnt[1]), 32'(done_cnt[0])});
        end
        force dut.pkt_cnt0 = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.pkt_cnt0;
        hi = rb_data[63:32];
        clear_obs();
        sync();
        add_pkt(0, 2, 1'b0, 0);
        wait_pkts(1, 100, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || rb_data[31:0] !== 32'd0 || rb_data[63:32] !== hi) begin
            errors++; $display("FAIL stats_wrap: got %h, need %h00000000", rb_data, hi);
        end
`else
        @(negedge clk);
        checks++;
        if (rb_data !== 64'd0) begin
            errors++; $display("FAIL stats_off: got %h, need 0", rb_data);
        end
`endif
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got no end of run, need finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_fixed_prio();
        test_disable_mid();
        test_stall();
        test_clear();
        test_random();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
